// File: rtl/superfx_gpr_file.sv
// superfx_gpr_file: SuperFX general-purpose register bank with byte-lane writes, PC increment and LOOP step.
// Latency: writes/LOOP/pc_inc land one cycle after the sampling edge; read ports are combinational.
// Backpressure: none, every input is sampled every cycle and back-to-back LOOP steps are accepted.
//
// Ports: clk/reset (sync, active-high); wr_en/wr_sel/wr_lane/wr_data = Z-bus writeback;
//        pc_inc, loop_en = PC sequencing; rd_a_sel/rd_b_sel -> rd_a/rd_b read ports;
//        regs_flat = every register, pc = reg PC_IDX, loop_taken = previous cycle's LOOP branched.
// Optional: define SUPERFX_GPR_BYPASS_EN to forward same-cycle explicit writes onto rd_a/rd_b.
module superfx_gpr_file #(
  parameter int                DATA_W       = 16,
  parameter int                NUM_REGS     = 16,
  parameter int                PC_IDX       = 15,
  parameter int                LOOP_CTR_IDX = 12,
  parameter int                LOOP_TGT_IDX = 13,
  parameter logic [DATA_W-1:0] RESET_PC     = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]   wr_sel,
  input  logic [DATA_W/8-1:0]           wr_lane,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          pc_inc,
  input  logic                          loop_en,
  input  logic [$clog2(NUM_REGS)-1:0]   rd_a_sel,
  input  logic [$clog2(NUM_REGS)-1:0]   rd_b_sel,
  output logic [DATA_W-1:0]             rd_a,
  output logic [DATA_W-1:0]             rd_b,
  output logic [NUM_REGS*DATA_W-1:0]    regs_flat,
  output logic [DATA_W-1:0]             pc,
  output logic                          loop_taken
);

  localparam int                SEL_W = $clog2(NUM_REGS);
  localparam int                LANES = DATA_W / 8;
  localparam logic [DATA_W-1:0] ONE   = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              loop_taken_q, loop_taken_d;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_base;
  logic [DATA_W-1:0] dec;
  logic              branch;

  // Byte-lane enables expanded to a bit mask.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_mask[8*i +: 8] = {8{wr_lane[i]}};
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end
    wr_base = '0;
    // Branch decision is taken from the counter before any same-cycle write.
    dec    = regs_q[LOOP_CTR_IDX] - ONE;
    branch = loop_en && (dec != '0);
    loop_taken_d = branch;

    if (loop_en) begin
      regs_d[LOOP_CTR_IDX] = dec;
    end
    // Target is read from the pre-write state, so a same-cycle target write is not seen.
    if (branch) begin
      regs_d[PC_IDX] = regs_q[LOOP_TGT_IDX];
    end else if (pc_inc) begin
      regs_d[PC_IDX] = regs_q[PC_IDX] + ONE;
    end

    // Explicit write has top priority on written lanes. A partial PC write merges with
    // the current PC; a partial counter write merges with the decremented value.
    if (wr_en && (|wr_lane)) begin
      if (wr_sel == SEL_W'(PC_IDX)) begin
        wr_base = regs_q[PC_IDX];
      end else begin
        wr_base = regs_d[wr_sel];
      end
      regs_d[wr_sel] = (wr_base & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k == PC_IDX) ? RESET_PC : '0;
      end
      loop_taken_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      loop_taken_q <= loop_taken_d;
    end
  end

  always_comb begin
    rd_a = regs_q[rd_a_sel];
    rd_b = regs_q[rd_b_sel];
`ifdef SUPERFX_GPR_BYPASS_EN
    // Forward explicit writes only; LOOP and pc_inc updates appear next cycle.
    if (wr_en && !reset && (rd_a_sel == wr_sel)) begin
      rd_a = (rd_a & ~wr_mask) | (wr_data & wr_mask);
    end
    if (wr_en && !reset && (rd_b_sel == wr_sel)) begin
      rd_b = (rd_b & ~wr_mask) | (wr_data & wr_mask);
    end
`endif
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign pc         = regs_q[PC_IDX];
  assign loop_taken = loop_taken_q;

endmodule

// File: tb/tb_superfx_gpr_file.sv
// tb_superfx_gpr_file: directed stimulus against superfx_gpr_file with a rule-level register model.
// Latency: model state advances on each rising edge; outputs are compared on the falling edge.
// Backpressure: none, the bench drives inputs every cycle.
module tb_superfx_gpr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [1:0]  wr_lane;
  logic [15:0] wr_data;
  logic        pc_inc;
  logic        loop_en;
  logic [3:0]  rd_a_sel;
  logic [3:0]  rd_b_sel;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic [255:0] regs_flat;
  logic [15:0] pc;
  logic        loop_taken;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [15:0] m [16];
  logic        m_lt;

  always #5 clk = ~clk;

  superfx_gpr_file dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
    .wr_data(wr_data), .pc_inc(pc_inc), .loop_en(loop_en), .rd_a_sel(rd_a_sel),
    .rd_b_sel(rd_b_sel), .rd_a(rd_a), .rd_b(rd_b), .regs_flat(regs_flat), .pc(pc),
    .loop_taken(loop_taken)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dreg(input int k);
    return regs_flat[k*16 +: 16];
  endfunction

  // Model read port: stored value, plus same-cycle explicit write when forwarding is built in.
  function automatic logic [15:0] mrd(input logic [3:0] sel);
    logic [15:0] r;
    r = m[sel];
`ifdef SUPERFX_GPR_BYPASS_EN
    if (wr_en && !reset && sel == wr_sel) begin
      if (wr_lane[0]) r[7:0]  = wr_data[7:0];
      if (wr_lane[1]) r[15:8] = wr_data[15:8];
    end
`endif
    return r;
  endfunction

  // Model: apply the operation rules to whole register values.
  always @(posedge clk) begin
    logic [15:0] nxt [16];
    logic [15:0] ctr_dec;
    logic        br;
    if (reset) begin
      foreach (m[k]) m[k] = 16'h0000;
      m_lt = 1'b0;
    end else begin
      nxt = m;
      ctr_dec = m[12] - 16'd1;
      br = loop_en && (ctr_dec != 16'd0);
      if (loop_en) nxt[12] = ctr_dec;
      if (br) nxt[15] = m[13];
      else if (pc_inc) nxt[15] = m[15] + 16'd1;
      if (wr_en && wr_lane != 2'b00) begin
        if (wr_sel == 4'd15) nxt[15] = m[15];
        if (wr_lane[0]) nxt[wr_sel][7:0]  = wr_data[7:0];
        if (wr_lane[1]) nxt[wr_sel][15:8] = wr_data[15:8];
      end
      m = nxt;
      m_lt = br;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [255:0] exp_flat;
      for (int k = 0; k < 16; k++) exp_flat[k*16 +: 16] = m[k];
      check("regs_flat", regs_flat, exp_flat);
      check("pc", {240'd0, pc}, {240'd0, m[15]});
      check("loop_taken", {255'd0, loop_taken}, {255'd0, m_lt});
      check("rd_a", {240'd0, rd_a}, {240'd0, mrd(rd_a_sel)});
      check("rd_b", {240'd0, rd_b}, {240'd0, mrd(rd_b_sel)});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    reset = 1'b0; wr_en = 1'b0; wr_sel = 4'd0; wr_lane = 2'b00; wr_data = 16'h0000;
    pc_inc = 1'b0; loop_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [1:0] lane, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_lane = lane; wr_data = d;
    tick();
    wr_en = 1'b0; wr_lane = 2'b00;
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    check(name, {240'd0, act}, {240'd0, exp});
  endtask

  initial begin
    idle();
    rd_a_sel = 4'd3; rd_b_sel = 4'd15;
    // Reset overrides a same-cycle write to reg 3.
    reset = 1'b1; wr_en = 1'b1; wr_sel = 4'd3; wr_lane = 2'b11; wr_data = 16'h1234;
    tick();
    idle();
    chk_en = 1'b1;
    lit("rst_reg3", dreg(3), 16'h0000);
    lit("rst_pc", pc, 16'h0000);
    lit("rst_lt", {15'd0, loop_taken}, 16'h0000);
    check("rst_all", regs_flat, 256'd0);

    // Byte-lane writes.
    rd_a_sel = 4'd4;
    wr(4'd4, 2'b11, 16'hAAAA);
    wr(4'd4, 2'b01, 16'h1255);
    lit("lane_lo", dreg(4), 16'hAA55);
    wr(4'd4, 2'b00, 16'hFFFF);
    lit("lane_none", dreg(4), 16'hAA55);

    // Three LOOP steps: two branches then fall-through with PC held.
    wr(4'd12, 2'b11, 16'h0003);
    wr(4'd13, 2'b11, 16'h0100);
    wr(4'd15, 2'b11, 16'h0200);
    loop_en = 1'b1;
    tick(); lit("loop1_ctr", dreg(12), 16'h0002); lit("loop1_pc", pc, 16'h0100);
    lit("loop1_lt", {15'd0, loop_taken}, 16'h0001);
    tick(); lit("loop2_ctr", dreg(12), 16'h0001); lit("loop2_pc", pc, 16'h0100);
    lit("loop2_lt", {15'd0, loop_taken}, 16'h0001);
    tick(); lit("loop3_ctr", dreg(12), 16'h0000); lit("loop3_pc", pc, 16'h0100);
    lit("loop3_lt", {15'd0, loop_taken}, 16'h0000);
    loop_en = 1'b0;
    tick();

    // Explicit PC write beats LOOP branch and pc_inc.
    wr(4'd12, 2'b11, 16'h0005);
    loop_en = 1'b1; pc_inc = 1'b1;
    wr(4'd15, 2'b11, 16'h4000);
    loop_en = 1'b0; pc_inc = 1'b0;
    lit("prio_pc", pc, 16'h4000); lit("prio_ctr", dreg(12), 16'h0004);
    lit("prio_lt", {15'd0, loop_taken}, 16'h0001);
    wr(4'd15, 2'b11, 16'hFFFF);
    pc_inc = 1'b1; tick();
    lit("pc_wrap", pc, 16'h0000);
    // Partial PC write merges with current PC, not the incremented one.
    wr(4'd15, 2'b10, 16'h12EE);
    pc_inc = 1'b0;
    lit("pc_partial", pc, 16'h1200);

    // Counter write vs decrement.
    wr(4'd12, 2'b11, 16'h0002);
    wr(4'd13, 2'b11, 16'h0300);
    loop_en = 1'b1;
    wr(4'd12, 2'b11, 16'h0009);
    loop_en = 1'b0;
    lit("ctr_conf", dreg(12), 16'h0009); lit("ctr_conf_pc", pc, 16'h0300);
    wr(4'd12, 2'b11, 16'h0102);
    loop_en = 1'b1;
    wr(4'd12, 2'b10, 16'h7700);
    loop_en = 1'b0;
    lit("ctr_partial", dreg(12), 16'h7701);

    // Counter zero wraps and branches; same-cycle target write uses old target.
    wr(4'd12, 2'b11, 16'h0000);
    wr(4'd13, 2'b11, 16'h0500);
    loop_en = 1'b1;
    wr(4'd13, 2'b11, 16'h0600);
    loop_en = 1'b0;
    lit("ctr_wrap", dreg(12), 16'hFFFF); lit("old_tgt_pc", pc, 16'h0500);
    lit("new_tgt", dreg(13), 16'h0600);

    // Read-port forwarding.
    wr(4'd7, 2'b11, 16'h00EF);
    rd_a_sel = 4'd7; rd_b_sel = 4'd7;
    wr_en = 1'b1; wr_sel = 4'd7; wr_lane = 2'b10; wr_data = 16'hBE00;
    #1;
`ifdef SUPERFX_GPR_BYPASS_EN
    lit("byp_same", rd_a, 16'hBEEF);
`else
    lit("byp_same", rd_a, 16'h00EF);
`endif
    tick();
    wr_en = 1'b0; wr_lane = 2'b00;
    lit("byp_next", rd_a, 16'hBEEF);

    // No forwarding during reset.
    rd_a_sel = 4'd4;
    reset = 1'b1; wr_en = 1'b1; wr_sel = 4'd4; wr_lane = 2'b11; wr_data = 16'h1111;
    #1;
    lit("rst_nobyp", rd_a, 16'hAA55);
    tick();
    idle();
    tick();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
